// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: sync, blank/DE, x/y, sof/eol.
// Optional frame counter port o_frame when VTG_FRAME_COUNT_EN is defined.
module video_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          i_clk,
  input  logic          i_arst,
  input  logic          i_en,
  output logic          o_hsync,
  output logic          o_vsync,
  output logic          o_blank,
  output logic          o_de,
  output logic [CW-1:0] o_x,
  output logic [CW-1:0] o_y,
  output logic          o_sof,
  output logic          o_eol
`ifdef VTG_FRAME_COUNT_EN
  ,
  output logic [15:0]   o_frame
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Reject degenerate regions and totals that overflow the counters.
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
      CW < 1 || H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad
    $error("video_timing_gen: illegal timing parameters");
  end

  localparam logic [CW-1:0] H_FP_AT  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] H_SY_AT  = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] H_BP_AT  = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_FP_AT  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] V_SY_AT  = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] V_BP_AT  = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    H_ACT, H_FPR, H_SYN, H_BPR
  } h_st_e;

  typedef enum logic [1:0] {
    V_ACT, V_FPR, V_SYN, V_BPR
  } v_st_e;

  logic [CW-1:0] hc_q, hc_d;
  logic [CW-1:0] vc_q, vc_d;
  h_st_e         hst_q;
  v_st_e         vst_q;
  logic          h_wrap, v_wrap;
  logic          de_c, vact_c, sof_c, eol_c;
  logic          hs_c, vs_c;

  // Next raster position and decode of the current one.
  always_comb begin
    h_wrap = (hc_q == H_LAST);
    v_wrap = (vc_q == V_LAST);
    hc_d   = h_wrap ? '0 : hc_q + CW'(1);
    vc_d   = vc_q;
    if (h_wrap) begin
      vc_d = v_wrap ? '0 : vc_q + CW'(1);
    end
    vact_c = (vst_q == V_ACT);
    de_c   = (hst_q == H_ACT) && vact_c;
    hs_c   = (hst_q == H_SYN) ? HS_POL : ~HS_POL;
    vs_c   = (vst_q == V_SYN) ? VS_POL : ~VS_POL;
    sof_c  = (hc_q == '0) && (vc_q == '0);
    eol_c  = h_wrap;
  end

  // Counters, region FSMs and registered outputs; all hold when i_en=0.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      hc_q    <= '0;
      vc_q    <= '0;
      hst_q   <= H_ACT;
      vst_q   <= V_ACT;
      o_hsync <= ~HS_POL;
      o_vsync <= ~VS_POL;
      o_blank <= 1'b1;
      o_de    <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
    end else if (i_en) begin
      o_hsync <= hs_c;
      o_vsync <= vs_c;
      o_blank <= ~de_c;
      o_de    <= de_c;
      o_x     <= de_c ? hc_q : '0;
      o_y     <= vact_c ? vc_q : '0;
      o_sof   <= sof_c;
      o_eol   <= eol_c;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      unique case (hst_q)
        H_ACT: if (hc_d == H_FP_AT) hst_q <= H_FPR;
        H_FPR: if (hc_d == H_SY_AT) hst_q <= H_SYN;
        H_SYN: if (hc_d == H_BP_AT) hst_q <= H_BPR;
        H_BPR: if (h_wrap)          hst_q <= H_ACT;
      endcase
      if (h_wrap) begin
        unique case (vst_q)
          V_ACT: if (vc_d == V_FP_AT) vst_q <= V_FPR;
          V_FPR: if (vc_d == V_SY_AT) vst_q <= V_SYN;
          V_SYN: if (vc_d == V_BP_AT) vst_q <= V_BPR;
          V_BPR: if (v_wrap)          vst_q <= V_ACT;
        endcase
      end
    end
  end

`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] frame_q;
  logic        seen_q;

  // Count frames from the second sof on; the first frame reads 0.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      frame_q <= '0;
      seen_q  <= 1'b0;
    end else if (i_en && sof_c) begin
      seen_q <= 1'b1;
      if (seen_q) begin
        frame_q <= frame_q + 16'd1;
      end
    end
  end

  assign o_frame = frame_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a small raster (8x6, frame = 48 enables).
// Reference outputs come from plain arithmetic on the enable count.
module tb_video_timing_gen;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic hsync, vsync, blank, de, sof, eol;
  logic [CW-1:0] x, y;
`ifdef VTG_FRAME_COUNT_EN
  logic [15:0] frame;
`endif

  int checks = 0;
  int errors = 0;
  int n_en = 0;
  int fr_adj = 0;

  always #5 clk = ~clk;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(CW)
  ) dut (
    .i_clk(clk), .i_arst(rst), .i_en(en),
    .o_hsync(hsync), .o_vsync(vsync),
    .o_blank(blank), .o_de(de),
    .o_x(x), .o_y(y),
    .o_sof(sof), .o_eol(eol)
`ifdef VTG_FRAME_COUNT_EN
    , .o_frame(frame)
`endif
  );

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h n_en=%0d",
             tag, got, exp, n_en);
    end
  endtask

  // Expected outputs after n enabled cycles since reset.
  task automatic check_all();
    int p, h, v;
    logic e_de;
    if (n_en == 0) begin
      chk("hsync", hsync, 0);
      chk("vsync", vsync, 0);
      chk("blank", blank, 1);
      chk("de", de, 0);
      chk("x", x, 0);
      chk("y", y, 0);
      chk("sof", sof, 0);
      chk("eol", eol, 0);
`ifdef VTG_FRAME_COUNT_EN
      chk("frame", frame, 0);
`endif
    end else begin
      p = (n_en - 1) % FRAME;
      h = p % HT;
      v = p / HT;
      e_de = (h < HA) && (v < VA);
      chk("hsync", hsync, 16'((h >= HA + HF) && (h < HA + HF + HS)));
      chk("vsync", vsync, 16'((v >= VA + VF) && (v < VA + VF + VS)));
      chk("blank", blank, 16'(!e_de));
      chk("de", de, 16'(e_de));
      chk("x", x, e_de ? 16'(h) : 16'd0);
      chk("y", y, (v < VA) ? 16'(v) : 16'd0);
      chk("sof", sof, 16'(p == 0));
      chk("eol", eol, 16'(h == HT - 1));
`ifdef VTG_FRAME_COUNT_EN
      chk("frame", frame, 16'((n_en - 1) / FRAME + fr_adj));
`endif
    end
  endtask

  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    if (e && !rst) n_en++;
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    check_all();
    rst = 1'b0;
    @(negedge clk);
    check_all();
    step(1'b0);
    step(1'b0);
    // Three full frames continuously enabled.
    for (int i = 0; i < 3 * FRAME; i++) step(1'b1);
    // Random stalls: outputs must follow only enabled cycles.
    for (int i = 0; i < 250; i++) step(1'(($urandom & 3) != 0));
    for (int i = 0; i < 100; i++) step(1'($urandom_range(0, 1)));
    // Walk to position (3,2), then reset asynchronously mid-frame.
    guard = 0;
    while (((n_en - 1) % FRAME) != 2 * HT + 3 && guard < 100) begin
      step(1'b1);
      guard++;
    end
    chk("walk_bound", 16'(guard < 100), 1);
    chk("pre_rst_x", x, 3);
    #2 rst = 1'b1;
    n_en = 0;
    fr_adj = 0;
    #1 check_all();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    step(1'b1);
    chk("post_rst_sof", sof, 1);
    for (int i = 0; i < 2 * FRAME; i++) step(1'($urandom_range(0, 1)));
`ifdef VTG_FRAME_COUNT_EN
    // Counter wraps from 0xFFFF to 0 at the next frame start.
    step(1'b1);
    while (((n_en - 1) % FRAME) == 0) step(1'b1);
    fr_adj = 16'hFFFF - ((n_en - 1) / FRAME);
    force dut.frame_q = 16'hFFFF;
    #1 release dut.frame_q;
    check_all();
    for (int i = 0; i < FRAME + 5; i++) step(1'b1);
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
